// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//   Avalon-MM read master that reads the system ID peripheral (word 0 = system
//   ID, word 1 = build timestamp) at boot or on request. It compares both words
//   against the expected values and reports sticky pass/fail status plus the
//   captured words, so a bitstream/software mismatch is visible without a CPU.
//
// Ports
//   clock            in   system clock
//   reset_n          in   asynchronous active-low reset
//   start            in   single-cycle pulse requesting a check
//   avm_address      out  word address (0 = ID, 1 = timestamp)
//   avm_read         out  read strobe (registered)
//   avm_readdata     in   [31:0] slave read data
//   avm_waitrequest  in   slave stall
//   busy             out  check in progress
//   done             out  sticky: check finished (pass, fail or timeout)
//   pass             out  sticky: both words matched, no timeout
//   id_mismatch      out  sticky: word 0 differed from EXPECTED_ID
//   ts_mismatch      out  sticky: word 1 differed from EXPECTED_TS
//   timeout          out  sticky: a read stalled TIMEOUT_CYCLES cycles
//   id_value         out  [31:0] captured word 0
//   ts_value         out  [31:0] captured word 1
// -----------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1617773073,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam bit          LAT1     = (READ_LATENCY != 0);
  // Abort fires on the stalled cycle that would make the count reach the limit.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        auto_q;
  logic [15:0] cnt_q, cnt_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        idmm_q, idmm_d;
  logic        tsmm_q, tsmm_d;
  logic        tmo_q, tmo_d;
  logic [31:0] idv_q, idv_d;
  logic [31:0] tsv_q, tsv_d;

  logic in_rd;
  logic accept;
  logic abort;
  logic go;
  logic launch;
  logic cap_id;
  logic cap_ts;

  assign in_rd  = (state_q == RD_ID) || (state_q == RD_TS);
  assign accept = in_rd && read_q && !avm_waitrequest;
  assign abort  = in_rd && avm_waitrequest && (cnt_q == TMO_LAST);
  // The power-up one-shot and a coincident start pulse merge into one launch.
  assign go     = start || auto_q;
  // FIN already reports busy=0, so a start there is honoured rather than lost.
  assign launch = ((state_q == IDLE) || (state_q == FIN)) && go;

  // With zero latency the data is sampled on the accept edge itself; with one
  // cycle of latency it is sampled on the edge leaving the LAT_x state.
  assign cap_id = LAT1 ? (state_q == LAT_ID) : ((state_q == RD_ID) && accept);
  assign cap_ts = LAT1 ? (state_q == LAT_TS) : ((state_q == RD_TS) && accept);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      auto_q  <= (AUTO_START != 0);
      cnt_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      idmm_q  <= 1'b0;
      tsmm_q  <= 1'b0;
      tmo_q   <= 1'b0;
      idv_q   <= '0;
      tsv_q   <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= 1'b0;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      idmm_q  <= idmm_d;
      tsmm_q  <= tsmm_d;
      tmo_q   <= tmo_d;
      idv_q   <= idv_d;
      tsv_q   <= tsv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RD_ID;
      RD_ID: begin
        if (accept)     state_d = LAT1 ? LAT_ID : RD_TS;
        else if (abort) state_d = FIN;
      end
      LAT_ID:  state_d = RD_TS;
      RD_TS: begin
        if (accept)     state_d = LAT1 ? LAT_TS : FIN;
        else if (abort) state_d = FIN;
      end
      LAT_TS:  state_d = FIN;
      FIN:     state_d = go ? RD_ID : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    idmm_d = idmm_q;
    tsmm_d = tsmm_q;
    tmo_d  = tmo_q;
    idv_d  = idv_q;
    tsv_d  = tsv_q;

    // Strobe and address come straight from the next state, so both are stable
    // for the whole stall. In zero-latency mode the strobe stays high across
    // the ID->TS hand-over because the ID data was already taken on accept.
    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);

    // Counts stalled cycles of the current read; any state change clears it.
    cnt_d = '0;
    if (in_rd && avm_waitrequest && !abort) cnt_d = cnt_q + 16'd1;

    if (launch) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      idmm_d = 1'b0;
      tsmm_d = 1'b0;
      tmo_d  = 1'b0;
      idv_d  = '0;
      tsv_d  = '0;
    end

    if (cap_id) begin
      idv_d  = avm_readdata;
      idmm_d = (avm_readdata != EXPECTED_ID);
    end

    if (cap_ts) begin
      tsv_d  = avm_readdata;
      tsmm_d = (avm_readdata != EXPECTED_TS);
    end

    if (abort) tmo_d = 1'b1;

    // Verdict is registered on entry to FIN, together with the final capture.
    if ((state_d == FIN) && (state_q != FIN)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = !idmm_d && !tsmm_d && !tmo_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = idmm_q;
  assign ts_mismatch = tsmm_q;
  assign timeout     = tmo_q;
  assign id_value    = idv_q;
  assign ts_value    = tsv_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (read latency 0 and 1, timeout 8,
// auto start on), each with its own Avalon slave model whose stall length per
// word is programmable. Results are compared against a table of hand-computed
// expectations and against a behavioural model for random transactions.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1617773073;
  localparam int          TMO    = 8;

  typedef struct {
    bit          pass, idmm, tsmm, tmo;
    logic [31:0] idv, tsv;
    int          cyc, nacc, w0, w1;
  } exp_t;

  typedef struct {
    int          inst;
    logic [31:0] id, ts;
    int          s0, s1;
    exp_t        e;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        start_s     [2];
  logic        avm_address [2];
  logic        avm_read    [2];
  logic [31:0] rdata       [2];
  logic        waitreq     [2];
  logic        busy        [2];
  logic        done        [2];
  logic        pass        [2];
  logic        idmm        [2];
  logic        tsmm        [2];
  logic        tmo         [2];
  logic [31:0] idv         [2];
  logic [31:0] tsv         [2];

  logic [31:0] mem_id  [2];
  logic [31:0] mem_ts  [2];
  int          stall_n [2][2];

  int checks   = 0;
  int failures = 0;

  int          obs_cyc, obs_n, obs_pend;
  int          obs_w [4];
  logic        obs_a [4];
  bit          obs_unstable, obs_to, obs_b1;
  logic [4:0]  obs_f1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int          stall_cnt;
    logic [31:0] rdq;

    sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .READ_LATENCY  (g),
      .TIMEOUT_CYCLES(TMO),
      .AUTO_START    (1)
    ) u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start_s[g]),
      .avm_address    (avm_address[g]),
      .avm_read       (avm_read[g]),
      .avm_readdata   (rdata[g]),
      .avm_waitrequest(waitreq[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .id_mismatch    (idmm[g]),
      .ts_mismatch    (tsmm[g]),
      .timeout        (tmo[g]),
      .id_value       (idv[g]),
      .ts_value       (tsv[g])
    );

    assign waitreq[g] = avm_read[g] &&
                        (stall_cnt < stall_n[g][avm_address[g] ? 1 : 0]);

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        stall_cnt <= 0;
        rdq       <= 32'h0;
      end else begin
        if (avm_read[g] && waitreq[g]) stall_cnt <= stall_cnt + 1;
        else                           stall_cnt <= 0;
        // Latency-1 slave: data valid only in the cycle after accept.
        if (avm_read[g] && !waitreq[g])
          rdq <= avm_address[g] ? mem_ts[g] : mem_id[g];
        else
          rdq <= $urandom;
      end
    end

    if (g == 0) begin : g_lat0
      assign rdata[g] = (avm_read[g] && !waitreq[g]) ?
                        (avm_address[g] ? mem_ts[g] : mem_id[g]) : 32'hA5A5_5A5A;
    end else begin : g_lat1
      assign rdata[g] = rdq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Spec-level reference: each completed read costs (stalls + 1 + latency)
  // cycles, a read stalled TMO cycles aborts the check, plus one launch cycle.
  function automatic exp_t model(input int lat, input logic [31:0] id, input logic [31:0] ts,
                                 input int s0, input int s1);
    exp_t e;
    e = '{default: 0};
    if (s0 >= TMO) begin
      e.tmo = 1;
      e.cyc = 1 + TMO;
    end else begin
      e.nacc = 1;
      e.w0   = s0 + 1;
      e.idv  = id;
      e.idmm = (id != EXP_ID);
      e.cyc  = 1 + s0 + 1 + lat;
      if (s1 >= TMO) begin
        e.tmo = 1;
        e.cyc += TMO;
      end else begin
        e.nacc = 2;
        e.w1   = s1 + 1;
        e.tsv  = ts;
        e.tsmm = (ts != EXP_TS);
        e.cyc += s1 + 1 + lat;
      end
    end
    e.pass = !e.idmm && !e.tsmm && !e.tmo;
    return e;
  endfunction

  // Called just after the launch edge; follows the bus until done rises.
  task automatic observe(input int i);
    int   width;
    logic prev;
    width        = 0;
    prev         = 1'b0;
    obs_cyc      = 0;
    obs_n        = 0;
    obs_unstable = 0;
    obs_to       = 0;
    obs_b1       = 0;
    obs_f1       = '0;
    for (int k = 0; k < 4; k++) begin
      obs_w[k] = 0;
      obs_a[k] = 1'b0;
    end
    forever begin
      @(negedge clock);
      obs_cyc++;
      if (obs_cyc == 1) begin
        obs_b1 = busy[i];
        obs_f1 = {done[i], pass[i], idmm[i], tsmm[i], tmo[i]};
      end
      if (done[i]) break;
      if (avm_read[i]) begin
        width++;
        if (width > 1 && avm_address[i] !== prev) obs_unstable = 1;
        prev = avm_address[i];
        if (!waitreq[i]) begin
          if (obs_n < 4) begin
            obs_a[obs_n] = avm_address[i];
            obs_w[obs_n] = width;
          end
          obs_n++;
          width = 0;
        end
      end
      if (obs_cyc >= 300) begin
        obs_to = 1;
        break;
      end
    end
    obs_pend = width;
  endtask

  task automatic compare(input int i, input exp_t e, input string tag);
    chk($sformatf("%s:finished_in_budget", tag), obs_to, 0);
    chk($sformatf("%s:cycles", tag), obs_cyc, e.cyc);
    chk($sformatf("%s:busy_after_launch", tag), obs_b1, 1);
    chk($sformatf("%s:flags_cleared_on_launch", tag), obs_f1, 0);
    chk($sformatf("%s:done", tag), done[i], 1);
    chk($sformatf("%s:busy_at_done", tag), busy[i], 0);
    chk($sformatf("%s:read_at_done", tag), avm_read[i], 0);
    chk($sformatf("%s:pass", tag), pass[i], e.pass);
    chk($sformatf("%s:id_mismatch", tag), idmm[i], e.idmm);
    chk($sformatf("%s:ts_mismatch", tag), tsmm[i], e.tsmm);
    chk($sformatf("%s:timeout", tag), tmo[i], e.tmo);
    chk($sformatf("%s:id_value", tag), idv[i], e.idv);
    chk($sformatf("%s:ts_value", tag), tsv[i], e.tsv);
    chk($sformatf("%s:accepts", tag), obs_n, e.nacc);
    chk($sformatf("%s:addr_stable", tag), obs_unstable, 0);
    chk($sformatf("%s:aborted_read_width", tag), obs_pend, e.tmo ? TMO : 0);
    if (e.nacc > 0) begin
      chk($sformatf("%s:addr0", tag), obs_a[0], 0);
      chk($sformatf("%s:width0", tag), obs_w[0], e.w0);
    end
    if (e.nacc > 1) begin
      chk($sformatf("%s:addr1", tag), obs_a[1], 1);
      chk($sformatf("%s:width1", tag), obs_w[1], e.w1);
    end
  endtask

  task automatic run_one(input int i, input logic [31:0] id, input logic [31:0] ts,
                         input int s0, input int s1, input exp_t e, input string tag);
    @(negedge clock);
    mem_id[i]     = id;
    mem_ts[i]     = ts;
    stall_n[i][0] = s0;
    stall_n[i][1] = s1;
    start_s[i]    = 1'b1;
    @(posedge clock);
    #1 start_s[i] = 1'b0;
    observe(i);
    compare(i, e, tag);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s:ctl%0d", tag, i),
          {busy[i], done[i], pass[i], idmm[i], tsmm[i], tmo[i], avm_read[i], avm_address[i]}, 0);
      chk($sformatf("%s:idv%0d", tag, i), idv[i], 0);
      chk($sformatf("%s:tsv%0d", tag, i), tsv[i], 0);
    end
  endtask

  task automatic check_inst1_passed(input string tag);
    chk($sformatf("%s:done1", tag), done[1], 1);
    chk($sformatf("%s:pass1", tag), pass[1], 1);
    chk($sformatf("%s:busy1", tag), busy[1], 0);
    chk($sformatf("%s:tsv1", tag), tsv[1], EXP_TS);
  endtask

  vec_t tbl [9];

  initial begin
    int   n_id;
    int   c;
    int   i;
    int   s0, s1;
    logic [31:0] id, ts;

    tbl[0] = '{0, 32'd0,        EXP_TS,          0,    0,    '{1,0,0,0, 32'd0,        EXP_TS,          3,  2, 1, 1}};
    tbl[1] = '{0, 32'd0,        32'h0000_0001,   0,    0,    '{0,0,1,0, 32'd0,        32'h0000_0001,   3,  2, 1, 1}};
    tbl[2] = '{0, 32'd5,        EXP_TS,          0,    0,    '{0,1,0,0, 32'd5,        EXP_TS,          3,  2, 1, 1}};
    tbl[3] = '{1, 32'd0,        EXP_TS,          4,    4,    '{1,0,0,0, 32'd0,        EXP_TS,          13, 2, 5, 5}};
    tbl[4] = '{0, 32'd0,        EXP_TS,          1000, 0,    '{0,0,0,1, 32'd0,        32'd0,           9,  0, 0, 0}};
    tbl[5] = '{1, 32'd0,        EXP_TS,          2,    1000, '{0,0,0,1, 32'd0,        32'd0,           13, 1, 3, 0}};
    tbl[6] = '{0, 32'd0,        EXP_TS,          7,    0,    '{1,0,0,0, 32'd0,        EXP_TS,          10, 2, 8, 1}};
    tbl[7] = '{1, 32'hFFFF_FFFF, EXP_TS ^ 32'd1, 0,    0,    '{0,1,1,0, 32'hFFFF_FFFF, EXP_TS ^ 32'd1, 5,  2, 1, 1}};
    tbl[8] = '{0, 32'd0,        EXP_TS,          0,    8,    '{0,0,0,1, 32'd0,        32'd0,           10, 1, 1, 0}};

    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k]    = 1'b0;
      mem_id[k]     = EXP_ID;
      mem_ts[k]     = EXP_TS;
      stall_n[k][0] = 0;
      stall_n[k][1] = 0;
    end
    #2 check_zero("por");

    // Power-up: both instances launch by themselves on the first edge.
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 observe(0);
    compare(0, model(0, EXP_ID, EXP_TS, 0, 0), "auto0");
    repeat (4) @(negedge clock);
    check_inst1_passed("auto1");

    for (int k = 0; k < 9; k++)
      run_one(tbl[k].inst, tbl[k].id, tbl[k].ts, tbl[k].s0, tbl[k].s1, tbl[k].e,
              $sformatf("vec%0d", k));

    // Extra starts during a check are dropped; a later one relaunches and
    // clears the sticky mismatch from the first check.
    @(negedge clock);
    mem_id[0] = EXP_ID; mem_ts[0] = 32'h0000_0001;
    stall_n[0][0] = 5; stall_n[0][1] = 5;
    start_s[0] = 1'b1;
    @(posedge clock);
    #1 start_s[0] = 1'b0;
    n_id = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (avm_read[0] && !waitreq[0] && !avm_address[0]) n_id++;
      start_s[0] = (k == 3 || k == 9);
    end
    start_s[0] = 1'b0;
    chk("dbl:id_reads_first", n_id, 1);
    chk("dbl:done_first", done[0], 1);
    chk("dbl:ts_mismatch_first", tsmm[0], 1);
    chk("dbl:busy_idle", busy[0], 0);
    run_one(0, EXP_ID, EXP_TS, 0, 0, model(0, EXP_ID, EXP_TS, 0, 0), "dbl_second");

    // Asynchronous reset in the middle of a stalled timestamp read.
    @(negedge clock);
    mem_id[0] = EXP_ID; mem_ts[0] = EXP_TS;
    stall_n[0][0] = 0; stall_n[0][1] = 1000;
    start_s[0] = 1'b1;
    @(posedge clock);
    #1 start_s[0] = 1'b0;
    c = 0;
    while (!(avm_read[0] && avm_address[0]) && c < 40) begin
      @(negedge clock);
      c++;
    end
    repeat (2) @(negedge clock);
    chk("rst:in_ts_stall", {avm_read[0], avm_address[0], busy[0]}, 3'b111);
    #1 reset_n = 1'b0;
    #1 check_zero("rst_mid");
    stall_n[0][1] = 0;
    mem_id[1] = EXP_ID; mem_ts[1] = EXP_TS;
    stall_n[1][0] = 0; stall_n[1][1] = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 observe(0);
    compare(0, model(0, EXP_ID, EXP_TS, 0, 0), "rst_auto0");
    repeat (4) @(negedge clock);
    check_inst1_passed("rst_auto1");

    // Random transactions against the reference model.
    for (int k = 0; k < 24; k++) begin
      i  = $urandom_range(0, 1);
      id = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      ts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      s0 = $urandom_range(0, 9);
      s1 = $urandom_range(0, 9);
      run_one(i, id, ts, s0, s1, model(i, id, ts, s0, s1), $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
